// File: rtl/pattern_scan_arbiter_if.sv
// Requester/consumer handshake bundle for pattern_scan_arbiter.
// The master side drives requests and response acceptance; the slave side is the arbiter.
interface pattern_scan_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [13:0]         rsp_indices;
  logic [3:0]          rsp_count;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_indices, rsp_count
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_indices, rsp_count
  );
endinterface

// File: rtl/pattern_scan_arbiter.sv
// Round-robin sharing of one registered "101" detector between N_REQ requesters.
// Optional response statistics counters are built when PATTERN_SCAN_STATS_EN is defined.
module pattern_scan_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  pattern_scan_arbiter_if.slave      bus,
  output logic [15:0]                det_data,
  input  logic [13:0]                det_match,
  output logic                       busy,
  output logic [15:0]                stat_words,
  output logic [15:0]                stat_matches
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]     det_data_q, det_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [13:0]     rsp_indices_q, rsp_indices_d;
  logic [3:0]      rsp_count_q, rsp_count_d;
  logic            busy_q, busy_d;

  logic [15:0]     req_word [N_REQ];
  logic            found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  logic [3:0]      match_cnt;
  logic [N_REQ-1:0] req_ready;
  logic            rsp_fire;

  // Round-robin scan starting at rr_ptr_q, wrapping at N_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_word[i] = bus.req_data[16*i +: 16];
    end
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!found && bus.req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < 14; i++) begin
      match_cnt = match_cnt + {3'b000, det_match[i]};
    end
  end

  assign rsp_fire = (state_q == StResp) && bus.rsp_ready;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    det_data_d    = det_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_indices_d = rsp_indices_q;
    rsp_count_d   = rsp_count_q;
    req_ready     = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          req_ready[grant_idx] = 1'b1;
          det_data_d           = req_word[grant_idx];
          rsp_id_d             = grant_idx;
          rr_ptr_d             = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d              = StIssue;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        rsp_indices_d = det_match;
        rsp_count_d   = match_cnt;
        rsp_valid_d   = 1'b1;
        state_d       = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // No grant may be signalled while the block is being reset.
    if (reset) begin
      req_ready = '0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      det_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_indices_q <= '0;
      rsp_count_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      det_data_q    <= det_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_indices_q <= rsp_indices_d;
      rsp_count_q   <= rsp_count_d;
      busy_q        <= busy_d;
    end
  end

`ifdef PATTERN_SCAN_STATS_EN
  logic [15:0] stat_words_q, stat_words_d;
  logic [15:0] stat_matches_q, stat_matches_d;
  logic [16:0] match_sum;

  // Both counters saturate rather than wrap.
  always_comb begin
    stat_words_d   = stat_words_q;
    stat_matches_d = stat_matches_q;
    match_sum      = {1'b0, stat_matches_q} + {13'd0, rsp_count_q};
    if (rsp_fire) begin
      if (stat_words_q != 16'hFFFF) begin
        stat_words_d = stat_words_q + 16'd1;
      end
      stat_matches_d = match_sum[16] ? 16'hFFFF : match_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_words_q   <= '0;
      stat_matches_q <= '0;
    end else begin
      stat_words_q   <= stat_words_d;
      stat_matches_q <= stat_matches_d;
    end
  end

  assign stat_words   = stat_words_q;
  assign stat_matches = stat_matches_q;
`else
  logic unused_fire;
  assign unused_fire  = rsp_fire;
  assign stat_words   = '0;
  assign stat_matches = '0;
`endif

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_indices = rsp_indices_q;
  assign bus.rsp_count   = rsp_count_q;
  assign det_data        = det_data_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Bench for pattern_scan_arbiter: transaction-level model plus directed literal checks.
module tb_pattern_scan_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] det_data;
  logic [13:0] det_match = '0;
  logic        busy;
  logic [15:0] stat_words;
  logic [15:0] stat_matches;
  int          checks = 0;
  int          failures = 0;
  logic        chk_en = 1'b0;

  pattern_scan_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

  pattern_scan_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .det_data     (det_data),
    .det_match    (det_match),
    .busy         (busy),
    .stat_words   (stat_words),
    .stat_matches (stat_matches)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] detect(input logic [15:0] w);
    logic [13:0] r;
    r = '0;
    for (int i = 0; i < 14; i++) begin
      if (w[i +: 3] == 3'b101) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int pick(input logic [3:0] v, input int ptr);
    int g;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    end
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered detector stand-in.
  always @(posedge clk) det_match <= detect(det_data);

  // Model: phase 0 idle, 1 issued, 2 detector result, 3 response pending.
  int          m_phase = 0;
  int          m_ptr = 0;
  logic [15:0] m_det = '0;
  logic [1:0]  m_id = '0;
  logic [13:0] m_idx = '0;
  logic [3:0]  m_cnt = '0;
  logic        m_rspv = 1'b0;
  int          m_words = 0;
  int          m_matches = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0; m_ptr <= 0; m_det <= '0; m_id <= '0; m_idx <= '0; m_cnt <= '0;
      m_rspv <= 1'b0; m_words <= 0; m_matches <= 0;
    end else begin
      case (m_phase)
        0: if (pick(bus.req_valid, m_ptr) >= 0) begin
          m_det   <= bus.req_data[16*pick(bus.req_valid, m_ptr) +: 16];
          m_id    <= 2'(pick(bus.req_valid, m_ptr));
          m_ptr   <= (pick(bus.req_valid, m_ptr) + 1) % N;
          m_phase <= 1;
        end
        1: m_phase <= 2;
        2: begin
          m_idx   <= detect(m_det);
          m_cnt   <= 4'($countones(detect(m_det)));
          m_rspv  <= 1'b1;
          m_phase <= 3;
        end
        default: if (bus.rsp_ready) begin
          m_rspv  <= 1'b0;
          m_phase <= 0;
`ifdef PATTERN_SCAN_STATS_EN
          m_words   <= (m_words + 1 > 65535) ? 65535 : m_words + 1;
          m_matches <= (m_matches + int'(m_cnt) > 65535) ? 65535 : m_matches + int'(m_cnt);
`endif
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] exp_rr;
      exp_rr = '0;
      if (!reset && m_phase == 0 && pick(bus.req_valid, m_ptr) >= 0)
        exp_rr = 4'(1 << pick(bus.req_valid, m_ptr));
      check("cmp_req_ready", 32'(bus.req_ready), 32'(exp_rr));
      check("cmp_busy", 32'(busy), 32'(m_phase != 0));
      check("cmp_det_data", 32'(det_data), 32'(m_det));
      check("cmp_rsp_valid", 32'(bus.rsp_valid), 32'(m_rspv));
      check("cmp_rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check("cmp_rsp_indices", 32'(bus.rsp_indices), 32'(m_idx));
      check("cmp_rsp_count", 32'(bus.rsp_count), 32'(m_cnt));
      check("cmp_stat_words", 32'(stat_words), 32'(m_words));
      check("cmp_stat_matches", 32'(stat_matches), 32'(m_matches));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          order [5] = '{0, 1, 2, 3, 0};
    logic [13:0] exp_idx [5] = '{14'h0002, 14'h0001, 14'h2000, 14'h0005, 14'h0002};
    logic [15:0] words [3] = '{16'h0005, 16'h5555, 16'h0000};

    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    tick;
    #2;
    check("reset_det_data", 32'(det_data), 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Single word from requester 0.
    reset = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_data[15:0] = 16'h0005;
    #2 check("single_grant", 32'(bus.req_ready), 32'h1);
    tick;
    bus.req_valid = '0;
    #2 check("single_det_data", 32'(det_data), 32'h0005);
    tick;
    #2 check("single_no_rsp_t2", 32'(bus.rsp_valid), 32'h0);
    tick;
    #2;
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("single_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("single_rsp_indices", 32'(bus.rsp_indices), 32'h0001);
    check("single_rsp_count", 32'(bus.rsp_count), 32'h1);
    tick;
    #2 check("single_idle", 32'(busy), 32'h0);

    // Dense pattern from requester 2.
    bus.req_valid = 4'b0100;
    bus.req_data[47:32] = 16'h5555;
    #2 check("dense_grant", 32'(bus.req_ready), 32'h4);
    tick;
    bus.req_valid = '0;
    tick;
    tick;
    #2;
    check("dense_rsp_indices", 32'(bus.rsp_indices), 32'h1555);
    check("dense_rsp_count", 32'(bus.rsp_count), 32'h7);
    check("dense_rsp_id", 32'(bus.rsp_id), 32'h2);
    tick;

    // Contention from reset release.
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data = {16'h0015, 16'hA000, 16'h0005, 16'h000A};
    #2 check("reset_req_ready", 32'(bus.req_ready), 32'h0);
    tick;
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #2 check("contend_grant", 32'(bus.req_ready), 32'(1 << order[n]));
      tick;
      if (n == 4) bus.req_valid = '0;
      tick;
      tick;
      #2;
      check("contend_rsp_id", 32'(bus.rsp_id), 32'(order[n]));
      check("contend_rsp_indices", 32'(bus.rsp_indices), 32'(exp_idx[n]));
      tick;
    end

    // Backpressure with requester 1 waiting.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_data[15:0] = 16'h0285;
    #2 check("bp_first_grant", 32'(bus.req_ready), 32'h1);
    tick;
    bus.req_valid = 4'b0010;
    bus.req_data[31:16] = 16'h0000;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_req_ready", 32'(bus.req_ready), 32'h0);
      check("bp_rsp_indices", 32'(bus.rsp_indices), 32'h0081);
      check("bp_rsp_count", 32'(bus.rsp_count), 32'h2);
      check("bp_rsp_id", 32'(bus.rsp_id), 32'h0);
      tick;
    end
    bus.rsp_ready = 1'b1;
    #2 check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
    tick;
    #2 check("bp_next_grant", 32'(bus.req_ready), 32'h2);
    tick;
    bus.req_valid = '0;
    tick;
    tick;
    #2;
    check("bp_second_id", 32'(bus.rsp_id), 32'h1);
    check("bp_second_count", 32'(bus.rsp_count), 32'h0);
    tick;

    // Reset in CAPTURE; rr_ptr would otherwise favour requester 3.
    bus.req_valid = 4'b0010;
    bus.req_data[31:16] = 16'h0005;
    #2 check("rst_first_grant", 32'(bus.req_ready), 32'h2);
    tick;
    bus.req_valid = '0;
    tick;
    reset = 1'b1;
    bus.req_valid = 4'b1010;
    bus.req_data[31:16] = 16'h0055;
    bus.req_data[63:48] = 16'hFFFF;
    #2;
    check("rst_busy_in_capture", 32'(busy), 32'h1);
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    tick;
    reset = 1'b0;
    #2;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_lowest_grant", 32'(bus.req_ready), 32'h2);
    tick;
    bus.req_valid = '0;
    tick;
    tick;
    #2;
    check("rst_rsp_indices", 32'(bus.rsp_indices), 32'h0015);
    check("rst_rsp_count", 32'(bus.rsp_count), 32'h3);
    tick;

    // Statistics over three words.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int w = 0; w < 3; w++) begin
      bus.req_valid = 4'b0001;
      bus.req_data[15:0] = words[w];
      tick;
      bus.req_valid = '0;
      tick;
      tick;
      tick;
    end
    #2;
`ifdef PATTERN_SCAN_STATS_EN
    check("stat_words", 32'(stat_words), 32'd3);
    check("stat_matches", 32'(stat_matches), 32'd8);
`else
    check("stat_words", 32'(stat_words), 32'd0);
    check("stat_matches", 32'(stat_matches), 32'd0);
`endif
    tick;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_scan_arbiter.md
# pattern_scan_arbiter

Shares one registered "101" pattern detector (16-bit `data_in` in, 14-bit match-index vector out, one-cycle latency) between `N_REQ` independent requesters. Requesters use valid/ready handshakes; words are accepted round-robin, passed through the detector one at a time, and returned with the requester ID, the match-index vector and a match count. The block sits between the requester front-ends and the detector instance, owning its `data_in` port.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of `rsp_id`. Must satisfy 2^`ID_W` >= `N_REQ`.
- `clk` input, 1: single clock. All logic is on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `req_valid` input, `N_REQ`: requester i has a word pending.
- `req_data` input, 16×`N_REQ`: requester i word at bits [16i+15:16i].
- `req_ready` output, `N_REQ`: one-hot accept strobe, combinational, asserted only in IDLE.
- `det_data` output, 16: drives the detector's `data_in`.
- `det_match` input, 14: the detector's `match_indices`.
- `rsp_valid` output, 1: result available.
- `rsp_ready` input, 1: consumer accepts the result.
- `rsp_id` output, `ID_W`: index of the requester that owns the result.
- `rsp_indices` output, 14: latched match-index vector.
- `rsp_count` output, 4: number of set bits in `rsp_indices`, range 0..7.
- `busy` output, 1: high in any state other than IDLE.
- `stat_words` output, 16: number of completed responses.
- `stat_matches` output, 16: sum of `rsp_count` over completed responses.

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is high, grant the first valid requester, searching upward from pointer `rr_ptr` with wrap-around.
  - Assert `req_ready[g]` for the granted requester only.
  - Load `det_data` ← `req_data[g]` and latch `g` into `rsp_id`.
  - Set `rr_ptr` ← (g+1) mod `N_REQ`, then go to ISSUE.
  - If no `req_valid` is high, stay in IDLE and keep `rr_ptr` unchanged.
- **ISSUE**: hold `det_data`; the detector samples it on this cycle's edge. Next state is CAPTURE.
- **CAPTURE**
  - Latch `rsp_indices` ← `det_match`.
  - Latch `rsp_count` ← popcount(`det_match`).
  - Next state is RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_id`, `rsp_indices` and `rsp_count` stay stable until the handshake.
  - On `rsp_valid`&&`rsp_ready`, go to IDLE.
- `req_ready` is 0 in every state except IDLE. A requester's word is taken only on its grant cycle.
- A requester may drop `req_valid` before being granted; no state is kept for it.
- `det_data` holds the last issued word between transactions.
- Reset values:
  - FSM=IDLE, `rr_ptr`=0.
  - `det_data`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_indices`=0, `rsp_count`=0.
  - `busy`=0, `stat_*`=0.
- Reset in any state, including mid-transaction:
  - The in-flight word is discarded and no response is produced.
  - `req_ready` is 0 during the reset cycle.
  - After the reset, `rr_ptr`=0.

## Timing
- Grant on cycle T (IDLE, `req_valid[g]`&&`req_ready[g]`).
- `det_data` is valid from T+1 (ISSUE).
- `det_match` is valid at T+2 (CAPTURE).
- `rsp_valid`=1 from T+3.
- With `rsp_ready` held high, the handshake occurs at T+3, IDLE is reached at T+4, and the next grant can occur at T+4. Peak throughput is one word per 4 cycles.
- Backpressure: `rsp_valid` stays high and all response outputs stay stable for as long as `rsp_ready`=0. No grant occurs during this time.
- `rsp_ready` asserted while `rsp_valid`=0 is ignored.

## Configuration
- Macro: `PATTERN_SCAN_STATS_EN`.
- Defined:
  - `stat_words` increments by 1 on each response handshake.
  - `stat_matches` adds `rsp_count` on each response handshake.
  - Both counters saturate at 16'hFFFF and are cleared by `reset`.
- Undefined:
  - Counter logic is not compiled.
  - `stat_words` and `stat_matches` remain as ports and are tied to 0.

## Test plan
- **Single word**: requester 0 sends 16'h0005 with `rsp_ready`=1.
  - Required: `rsp_valid` at T+3, `rsp_id`=0, `rsp_indices`=14'h0001, `rsp_count`=1.
- **Dense pattern**: requester 2 sends 16'h5555.
  - Required: `rsp_indices`=14'h1555, `rsp_count`=7, `rsp_id`=2.
- **Contention**: all 4 `req_valid` high from reset release with distinct data.
  - Required: grants in order 0, 1, 2, 3, then 0, each 4 cycles apart. `rsp_id` follows the same order.
- **Backpressure**: `rsp_ready`=0 for 5 cycles in RESP while requester 1 is valid.
  - Required: response outputs stable and `req_ready`=0 throughout.
  - Required: grant to requester 1 one cycle after `rsp_ready` rises.
- **Reset mid-operation**: assert `reset` in CAPTURE.
  - Required: next cycle `rsp_valid`=0, `busy`=0.
  - Required: the next grant goes to the lowest-indexed valid requester (`rr_ptr`=0).
- **Statistics** (`PATTERN_SCAN_STATS_EN` defined): complete 16'h0005, 16'h5555, 16'h0000.
  - Required: `stat_words`=3, `stat_matches`=8.
  - Required: with the macro undefined, both counters stay 0.
